// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3: sliding 3x3 pixel window for the Sobel datapath.
// Tracks row/column position and flags windows centred on interior pixels.
module sobel_window_3x3 #(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 128,
  parameter int FRAME_HEIGHT = 128,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    SOF,
  input  logic [DATA_WIDTH-1:0]   DataIn,
  input  logic [DATA_WIDTH-1:0]   Row1In,
  input  logic [DATA_WIDTH-1:0]   Row2In,
  output logic [9*DATA_WIDTH-1:0] Window,
  output logic                    WindowValid,
  output logic [CNT_WIDTH-1:0]    CenterRow,
  output logic [CNT_WIDTH-1:0]    CenterCol,
  output logic                    FrameDone
);

  localparam logic [CNT_WIDTH-1:0] COL_LAST =
    CNT_WIDTH'(LINE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST =
    CNT_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  logic [8:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0]       row_q, row_d;
  logic [CNT_WIDTH-1:0]       col_q, col_d;
  logic [CNT_WIDTH-1:0]       crow_q, crow_d;
  logic [CNT_WIDTH-1:0]       ccol_q, ccol_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;

  logic [CNT_WIDTH-1:0] pix_row;
  logic [CNT_WIDTH-1:0] pix_col;
  logic                 interior;
  logic                 last_col;
  logic                 last_row;

  // SOF relabels the accepted pixel as (0,0) whatever the counters say
  always_comb begin
    pix_row  = SOF ? '0 : row_q;
    pix_col  = SOF ? '0 : col_q;
    interior = (pix_row >= TWO) && (pix_col >= TWO);
    last_col = (pix_col == COL_LAST);
    last_row = (pix_row == ROW_LAST);
  end

  always_comb begin
    win_d   = win_q;
    row_d   = row_q;
    col_d   = col_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (Enable) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = Row2In;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = Row1In;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = DataIn;
      valid_d  = interior;
      done_d   = last_row && last_col;
      if (interior) begin
        crow_d = pix_row - ONE;
        ccol_d = pix_col - ONE;
      end
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : pix_row + ONE;
      end else begin
        col_d = pix_col + ONE;
        row_d = pix_row;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      crow_q  <= '0;
      ccol_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      row_q   <= row_d;
      col_q   <= col_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Window      = win_q;
  assign WindowValid = valid_q;
  assign CenterRow   = crow_q;
  assign CenterCol   = ccol_q;
  assign FrameDone   = done_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb_sobel_window_3x3: table vectors on a 4x4 instance plus a
// randomized two-frame run on the default 128x128 instance.
module tb_sobel_window_3x3;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       SOF = 1'b0;
  logic [7:0] DataIn = '0;
  logic [7:0] Row1In = '0;
  logic [7:0] Row2In = '0;

  logic [71:0] win_s, win_b;
  logic        val_s, val_b;
  logic        done_s, done_b;
  logic [7:0]  cr_s, cc_s, cr_b, cc_b;

  int n_tests = 0;
  int n_fail = 0;
  int idx = 0;
  int n_val = 0;
  int n_done = 0;

  logic [7:0] img [128][128];

  typedef struct {
    int          cr;
    int          cc;
    logic [71:0] win;
  } vec_t;

  vec_t tbl [4];
  vec_t got [$];

  always #5 CLK = ~CLK;

  sobel_window_3x3 #(
    .DATA_WIDTH(8), .LINE_WIDTH(4),
    .FRAME_HEIGHT(4), .CNT_WIDTH(8)
  ) dut_s (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .SOF(SOF),
    .DataIn(DataIn), .Row1In(Row1In), .Row2In(Row2In),
    .Window(win_s), .WindowValid(val_s),
    .CenterRow(cr_s), .CenterCol(cc_s), .FrameDone(done_s)
  );

  sobel_window_3x3 dut_b (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .SOF(SOF),
    .DataIn(DataIn), .Row1In(Row1In), .Row2In(Row2In),
    .Window(win_b), .WindowValid(val_b),
    .CenterRow(cr_b), .CenterCol(cc_b), .FrameDone(done_b)
  );

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model labels pixels by frame index
  task automatic pix(input bit en, input bit sof,
                     input bit big, input bit pat);
    int w, r, c;
    bit ev, ed;
    logic [71:0] ew, aw;
    logic v, dn;
    logic [7:0] ar, ac;
    vec_t g;
    w = big ? 128 : 4;
    if (en && sof) idx = 0;
    r = idx / w;
    c = idx % w;
    Enable = en;
    SOF = sof;
    DataIn = (pat && en) ? 8'(r * 16 + c) : 8'($urandom);
    Row1In = (r >= 1) ? img[r-1][c] : 8'($urandom);
    Row2In = (r >= 2) ? img[r-2][c] : 8'($urandom);
    if (en) img[r][c] = DataIn;
    ev = en && r >= 2 && c >= 2;
    ed = en && r == w - 1 && c == w - 1;
    ew = '0;
    if (ev)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          ew[8*(i*3+j) +: 8] = img[r-2+i][c-2+j];
    @(posedge CLK);
    #1;
    v  = big ? val_b : val_s;
    dn = big ? done_b : done_s;
    aw = big ? win_b : win_s;
    ar = big ? cr_b : cr_s;
    ac = big ? cc_b : cc_s;
    chk("valid", 72'(v), 72'(ev));
    chk("framedone", 72'(dn), 72'(ed));
    if (ev) begin
      chk("window", aw, ew);
      chk("center_row", 72'(ar), 72'(r - 1));
      chk("center_col", 72'(ac), 72'(c - 1));
    end
    if (v) n_val++;
    if (dn) n_done++;
    if (v && !big) begin
      g.cr = int'(ar);
      g.cc = int'(ac);
      g.win = aw;
      got.push_back(g);
    end
    if (en) idx = (idx + 1) % (w * w);
  endtask

  task automatic do_reset();
    Enable = 1'b0;
    SOF = 1'b0;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    idx = 0;
    n_val = 0;
    n_done = 0;
    got.delete();
  endtask

  task automatic cmp_table(input string tag);
    chk({tag, "_count"}, 72'(got.size()), 72'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk({tag, "_crow"}, 72'(got[i].cr), 72'(tbl[i].cr));
        chk({tag, "_ccol"}, 72'(got[i].cc), 72'(tbl[i].cc));
        chk({tag, "_win"}, got[i].win, tbl[i].win);
      end
    end
  endtask

  initial begin
    tbl[0] = '{1, 1, 72'h222120121110020100};
    tbl[1] = '{1, 2, 72'h232221131211030201};
    tbl[2] = '{2, 1, 72'h323130222120121110};
    tbl[3] = '{2, 2, 72'h333231232221131211};

    // async reset mid-cycle while Enable is high
    do_reset();
    for (int i = 0; i < 11; i++) pix(1, 0, 0, 1);
    #2 Reset = 1'b1;
    #1;
    chk("rst_window", win_s, 72'd0);
    chk("rst_valid", 72'(val_s), 72'd0);
    chk("rst_crow", 72'(cr_s), 72'd0);
    chk("rst_ccol", 72'(cc_s), 72'd0);
    chk("rst_done", 72'(done_s), 72'd0);
    #2 Reset = 1'b0;
    idx = 0;
    n_val = 0;
    n_done = 0;
    got.delete();

    // 4x4 continuous frame, then a second frame without SOF
    for (int i = 0; i < 16; i++) pix(1, 0, 0, 1);
    cmp_table("cont");
    chk("cont_framedone_cnt", 72'(n_done), 72'd1);
    n_val = 0;
    n_done = 0;
    for (int i = 0; i < 16; i++) pix(1, 0, 0, 1);
    chk("frame2_valid_cnt", 72'(n_val), 72'd4);
    chk("frame2_done_cnt", 72'(n_done), 72'd1);

    // Enable toggled every other cycle
    do_reset();
    for (int i = 0; i < 32; i++) pix(i % 2 == 0, 0, 0, 1);
    cmp_table("toggle");

    // SOF mid-frame at row 2, col 3
    do_reset();
    for (int i = 0; i < 11; i++) pix(1, 0, 0, 1);
    n_val = 0;
    n_done = 0;
    got.delete();
    pix(1, 1, 0, 1);
    for (int i = 0; i < 15; i++) pix(1, 0, 0, 1);
    cmp_table("sof");
    chk("sof_done_cnt", 72'(n_done), 72'd1);

    // default geometry, random pixels, two frames
    do_reset();
    for (int i = 0; i < 2 * 128 * 128; i++) pix(1, 0, 1, 0);
    chk("big_valid_cnt", 72'(n_val), 72'd31752);
    chk("big_done_cnt", 72'(n_done), 72'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Consumer end of the line-buffer chain in the Sobel datapath.
- Takes the live pixel stream and the two row-delayed taps produced by the cascaded 128-cell line FIFOs.
- Assembles a sliding 3x3 pixel window and tracks row/column position.
- Flags windows whose centre is an interior pixel, so the downstream gradient stage sees only complete neighbourhoods.

Parameters:
DATA_WIDTH, 8, bits per pixel
LINE_WIDTH, 128, pixels per image row; must equal line FIFO depth
FRAME_HEIGHT, 128, rows per frame
CNT_WIDTH, 8, row/column counter width; must satisfy 2^CNT_WIDTH >= max(LINE_WIDTH, FRAME_HEIGHT)

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Enable  input  1  pixel accept strobe; one pixel consumed per rising CLK edge with Enable=1
SOF  input  1  start of frame; qualified by Enable; marks DataIn as row 0, col 0
DataIn  input  DATA_WIDTH  current-row pixel (bottom window row)
Row1In  input  DATA_WIDTH  pixel one line earlier, same column (first line FIFO DataOut)
Row2In  input  DATA_WIDTH  pixel two lines earlier, same column (second line FIFO DataOut)
Window  output  9*DATA_WIDTH  packed window; element k=r*3+c at bits [DATA_WIDTH*k +: DATA_WIDTH]; r=0 top (oldest row), c=0 left (oldest column); k=8 is most recent DataIn
WindowValid  output  1  one-cycle pulse: Window holds a complete interior neighbourhood
CenterRow  output  CNT_WIDTH  row index of window centre pixel
CenterCol  output  CNT_WIDTH  column index of window centre pixel
FrameDone  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface timing:
  - One clock domain, CLK.
  - Reset is asynchronous and active-high.
  - Integrator aligns Row1In/Row2In so that all three inputs carry the same column in the same enabled cycle.
- Reset values: Window=0, WindowValid=0, CenterRow=0, CenterCol=0, FrameDone=0.
  - Internal counters: row=0, col=0.
  - Reset mid-frame discards the partial frame; the next accepted pixel is row 0, col 0.
- Enabled cycle (Enable=1):
  - For each r: W[r][0]<=W[r][1], W[r][1]<=W[r][2].
  - W[0][2]<=Row2In, W[1][2]<=Row1In, W[2][2]<=DataIn.
- Disabled cycle (Enable=0): window, counters and Center outputs hold; WindowValid=0, FrameDone=0.
- Pixel position:
  - (row,col) labels the pixel on DataIn in the current enabled cycle.
  - After acceptance col increments.
  - At col=LINE_WIDTH-1, col wraps to 0 and row increments.
  - At row=FRAME_HEIGHT-1, col=LINE_WIDTH-1, both wrap to 0.
- SOF:
  - Enable=1 with SOF=1 forces the accepted pixel to be treated as row 0, col 0, regardless of counter state.
  - The counters then continue from row 0, col 1.
  - SOF without Enable is ignored.
- WindowValid:
  - Registered; asserted in the cycle after an enabled cycle that accepted a pixel with row>=2 and col>=2.
  - Latency: 1 clock from accept edge to valid Window.
  - Same cycle: CenterRow=row-1, CenterCol=col-1 of the accepted pixel.
  - Border centres (row 0, row H-1, col 0, col W-1) never produce WindowValid.
  - Windows straddling a row wrap (col<2) are suppressed.
- FrameDone: registered pulse in the cycle after acceptance of pixel (FRAME_HEIGHT-1, LINE_WIDTH-1). It coincides with that pixel's WindowValid.
- Back-to-back: continuous Enable=1 gives one WindowValid per interior pixel; no bubbles inserted.
- Counts per frame: WindowValid pulses = (LINE_WIDTH-2)*(FRAME_HEIGHT-2); FrameDone = 1.
- No internal storage beyond 9 window registers, counters and output flags; no backpressure.

Test Plan:
1. Reset: assert Reset asynchronously mid-cycle with Enable=1 -> all outputs 0 immediately; first accept after release labelled (0,0).
2. LINE_WIDTH=4, FRAME_HEIGHT=4; stream pixel value = row*16+col with Row1In/Row2In = value of rows r-1/r-2, continuous Enable:
   - -> WindowValid pulses exactly 4 times, centres (1,1),(1,2),(2,1),(2,2).
   - -> at centre (1,1), Window k0..k8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
3. Same stream with Enable toggled every other cycle -> identical Window contents and centre sequence; WindowValid never high on a cycle following Enable=0.
4. FrameDone: 4x4 frame -> single FrameDone pulse aligned with centre (2,2); the next frame's first pixel is labelled (0,0) without SOF.
5. SOF mid-frame at row 2, col 3 with Enable=1 -> that pixel labelled (0,0); no WindowValid until row 2, col 2 of the new frame.
6. Defaults (128x128), random pixels, 2 frames -> 126*126=15876 WindowValid pulses per frame and 2 FrameDone pulses; scoreboard compares Window against a software 3x3 model.
